commit_halt_monitor: RTL and testbench
======================================

Name: commit_halt_monitor

Overview:
- Sits directly downstream of the Tomasulo core's reorder buffer (ROB) commit port, inside the simulation/FPGA top.
- Consumes the in-order retire stream and detects program termination on a committed ECALL/EBREAK.
- Stops fetch, waits for the ROB and store queue to drain, then raises the top-level `done` with pass/fail status.
- Runs a watchdog so a hung core still terminates with a fail.

Parameters:
- TIMEOUT_CYCLES, 100000, watchdog limit counted in RUN state; 0 disables the watchdog.
- DRAIN_MAX, 64, maximum DRAIN cycles before a forced fail.
- CNT_W, 32, width of the cycle and retire counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  1  ROB retires one instruction this cycle.
- commit_pc  in  32  PC of the retiring instruction.
- commit_instr  in  32  raw encoding of the retiring instruction.
- commit_rd_we  in  1  retiring instruction writes rd.
- commit_rd  in  5  destination register index.
- commit_rd_value  in  32  value written to rd.
- rob_empty  in  1  ROB holds no entries.
- sq_empty  in  1  store queue/buffer fully drained to memory.
- halt_fetch  out  1  tells fetch to stop issuing new instructions.
- done  out  1  sticky; test finished.
- pass  out  1  valid when done; exit code is 0.
- fail  out  1  valid when done; nonzero exit code, timeout, or drain overrun.
- timeout  out  1  the fail was caused by the watchdog or DRAIN_MAX.
- exit_code  out  32  latched a0 (x10) value at the halt commit.
- retired_count  out  CNT_W  number of instructions committed.
- cycle_count  out  CNT_W  cycles since reset deassertion; frozen once done.
- signature  out  32  commit signature (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): state=RUN; all outputs 0; a0 shadow=0.
- a0 shadow register:
  - Updated when commit_valid && commit_rd_we && commit_rd==10, taking commit_rd_value.
  - Writes with commit_rd==0 are ignored.
- Halt decode: commit_valid && (commit_instr==32'h00000073 || commit_instr==32'h00100073).
- States RUN, DRAIN, DONE; all transitions are registered.
- RUN:
  - retired_count increments on every commit_valid, including the halt instruction itself.
  - cycle_count increments every cycle.
  - On a halt commit: exit_code latches the a0 shadow, or commit_rd_value if the same-cycle commit writes x10. halt_fetch=1 from the next cycle. Go to DRAIN.
  - If TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1: go to DONE with fail=1, timeout=1. A halt commit in that same cycle takes priority (go to DRAIN).
- DRAIN:
  - halt_fetch held at 1.
  - Drain counter is cleared on DRAIN entry and increments each cycle.
  - Any commit_valid in DRAIN is a protocol error → DONE with fail=1 (younger instructions must already be flushed by the ROB).
  - rob_empty && sq_empty → DONE.
  - If the drain counter reaches DRAIN_MAX first → DONE with fail=1, timeout=1.
- DONE:
  - done=1, pass=(exit_code==0 && !timeout && !error), fail=!pass.
  - All outputs frozen and halt_fetch held at 1 until reset.
- Width rules: counters wrap modulo 2^CNT_W (no saturation).
- Outputs are registered; done rises exactly 1 cycle after the cycle in which drain completes.
- Reset mid-DRAIN or in DONE returns to RUN with everything cleared.

Optional Feature:
- Macro COMMIT_SIG_EN.
- When defined, signature is updated on each commit_valid in RUN as sig <= {sig[30:0],sig[31]} ^ commit_pc ^ (commit_rd_we ? commit_rd_value : 32'h0).
- The update is frozen after leaving RUN.
- When not defined, signature is constant 0 and no signature logic is built; the port list is identical in both builds.

Decomposition:
- Shared package (tomasulo_pkg) holds:
  - INSTR_ECALL and INSTR_EBREAK constants.
  - REG_A0=5'd10.
  - The monitor state enum typedef (RUN/DRAIN/DONE).
- One sub-module, halt_decode: combinational classification of commit_instr into is_ecall/is_ebreak.
- The FSM, counters and signature stay in the parent.

Test Plan:
- Commit `li a0,0` (rd=10, value 0), then ECALL; ROB/SQ report empty 3 cycles later → halt_fetch next cycle, done=1, pass=1, exit_code=0, retired_count=2.
- a0=5, then EBREAK → done=1, fail=1, timeout=0, exit_code=5.
- ECALL committed in the same cycle as a write of rd=10 value 7 → exit_code=7, fail=1.
- TIMEOUT_CYCLES=50, no halt commit → done at cycle 51, fail=1, timeout=1, cycle_count=50.
- Halt commit with sq_empty held at 0 for DRAIN_MAX=8 → fail=1, timeout=1. Separately, commit_valid during DRAIN → fail=1, timeout=0.
- Assert reset asynchronously mid-DRAIN → all outputs 0 immediately. Then the sequence a0=0, ECALL passes again. With COMMIT_SIG_EN, the signature matches the golden model value for a fixed 4-commit trace.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg
//   Definitions shared by the commit-stream halt monitor: the two
//   instruction encodings that terminate a test, the index of a0, the
//   monitor state type and the commit signature step function.
//   No ports (package).
package tomasulo_pkg;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [4:0]  REG_A0       = 5'd10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } mon_state_e;

  // One step of the commit signature: rotate left by one, then fold in the
  // PC and, when the instruction writes a register, the written value.
  function automatic logic [31:0] sig_next(input logic [31:0] sig,
                                           input logic [31:0] pc,
                                           input logic        rd_we,
                                           input logic [31:0] rd_value);
    return {sig[30:0], sig[31]} ^ pc ^ (rd_we ? rd_value : 32'h0);
  endfunction

endpackage

// File: rtl/commit_halt_monitor_if.sv
// commit_halt_monitor_if
//   In-order retire stream from the ROB commit port.
//   Signals:
//     commit_valid     one instruction retires this cycle
//     commit_pc        PC of the retiring instruction
//     commit_instr     raw encoding of the retiring instruction
//     commit_rd_we     retiring instruction writes rd
//     commit_rd        destination register index
//     commit_rd_value  value written to rd
//   Modports: master (ROB side, drives), slave (monitor side, observes).
interface commit_halt_monitor_if;

  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        commit_rd_we;
  logic [4:0]  commit_rd;
  logic [31:0] commit_rd_value;

  modport master (
    output commit_valid,
    output commit_pc,
    output commit_instr,
    output commit_rd_we,
    output commit_rd,
    output commit_rd_value
  );

  modport slave (
    input commit_valid,
    input commit_pc,
    input commit_instr,
    input commit_rd_we,
    input commit_rd,
    input commit_rd_value
  );

endinterface

// File: rtl/commit_halt_monitor_halt_decode.sv
// halt_decode
//   Combinational classification of a retiring instruction word as one of
//   the two test-terminating system instructions.
//   Ports:
//     instr      in   32  raw instruction encoding
//     is_ecall   out  1   encoding is exactly ECALL
//     is_ebreak  out  1   encoding is exactly EBREAK
module halt_decode
  import tomasulo_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_ecall,
  output logic        is_ebreak
);

  // Whole-word compares: any other SYSTEM encoding (CSR ops, xRET, WFI)
  // must not end the test.
  assign is_ecall  = (instr == INSTR_ECALL);
  assign is_ebreak = (instr == INSTR_EBREAK);

endmodule

// File: rtl/commit_halt_monitor.sv
// commit_halt_monitor
//   Watches the in-order retire stream. A committed ECALL/EBREAK stops
//   fetch, the monitor waits for the ROB and store queue to drain, then
//   raises a sticky done with pass/fail. A watchdog in RUN and a bound on
//   the drain phase make a hung core still finish with a fail.
//   Optional build macro: COMMIT_SIG_EN enables the commit signature;
//   without it signature is tied to 0 (port list unchanged).
//   Ports:
//     clk            in   1      system clock
//     reset          in   1      asynchronous, active-high reset
//     commit         slave       retire stream (commit_halt_monitor_if)
//     rob_empty      in   1      ROB holds no entries
//     sq_empty       in   1      store queue fully drained to memory
//     halt_fetch     out  1      stop fetching new instructions
//     done           out  1      sticky, test finished
//     pass           out  1      valid with done, exit code 0
//     fail           out  1      valid with done, any failure cause
//     timeout        out  1      failure came from watchdog or drain bound
//     exit_code      out  32     a0 value at the halt commit
//     retired_count  out  CNT_W  instructions committed
//     cycle_count    out  CNT_W  cycles since reset, frozen once done
//     signature      out  32     commit signature (0 when disabled)
module commit_halt_monitor
  import tomasulo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DRAIN_MAX      = 64,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  commit_halt_monitor_if.slave commit,
  input  logic                 rob_empty,
  input  logic                 sq_empty,
  output logic                 halt_fetch,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [31:0]          exit_code,
  output logic [CNT_W-1:0]     retired_count,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [31:0]          signature
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

  mon_state_e         state_q;
  mon_state_e         state_d;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [31:0]        a0_shadow;

  logic is_ecall;
  logic is_ebreak;
  logic halt_commit;
  logic a0_write;
  logic go_drain;
  logic go_done;
  logic end_timeout;
  logic end_error;
  logic pass_next;

  halt_decode u_halt_decode (
    .instr     (commit.commit_instr),
    .is_ecall  (is_ecall),
    .is_ebreak (is_ebreak)
  );

  assign halt_commit = commit.commit_valid && (is_ecall || is_ebreak);

  // Only x10 writes matter, so writes to x0 are excluded by construction.
  assign a0_write = commit.commit_valid && commit.commit_rd_we &&
                    (commit.commit_rd == REG_A0);

  // exit_code already holds the latched a0 by the time DONE is entered
  // from DRAIN; a watchdog exit from RUN fails through end_timeout.
  assign pass_next = (exit_code == 32'd0) && !end_timeout && !end_error;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A halt commit beats the watchdog in the same cycle;
  // in DRAIN a stray commit beats a clean drain, which beats the bound.
  always_comb begin
    state_d     = state_q;
    go_drain    = 1'b0;
    go_done     = 1'b0;
    end_timeout = 1'b0;
    end_error   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_commit) begin
          state_d  = ST_DRAIN;
          go_drain = 1'b1;
        end else if (WDOG_EN && (cycle_count == TIMEOUT_LAST)) begin
          state_d     = ST_DONE;
          go_done     = 1'b1;
          end_timeout = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (commit.commit_valid) begin
          state_d   = ST_DONE;
          go_done   = 1'b1;
          end_error = 1'b1;
        end else if (rob_empty && sq_empty) begin
          state_d = ST_DONE;
          go_done = 1'b1;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_d     = ST_DONE;
          go_done     = 1'b1;
          end_timeout = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Counters, a0 shadow and the registered status outputs. Everything
  // stops moving once DONE is reached, so the final values stay readable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_fetch    <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      exit_code     <= 32'd0;
      retired_count <= '0;
      cycle_count   <= '0;
      drain_cnt     <= '0;
      a0_shadow     <= 32'd0;
    end else begin
      if (state_q != ST_DONE) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (state_q == ST_RUN) begin
        if (commit.commit_valid) begin
          retired_count <= retired_count + 1'b1;
        end
        if (a0_write) begin
          a0_shadow <= commit.commit_rd_value;
        end
      end
      if (state_q == ST_DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
      if (go_drain) begin
        exit_code  <= a0_write ? commit.commit_rd_value : a0_shadow;
        halt_fetch <= 1'b1;
        drain_cnt  <= '0;
      end
      if (go_done) begin
        halt_fetch <= 1'b1;
        done       <= 1'b1;
        pass       <= pass_next;
        fail       <= !pass_next;
        timeout    <= end_timeout;
      end
    end
  end

`ifdef COMMIT_SIG_EN
  logic [31:0] sig_q;

  // Signature folds in every instruction retired while running,
  // including the halt instruction itself, and freezes afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 32'd0;
    end else if ((state_q == ST_RUN) && commit.commit_valid) begin
      sig_q <= sig_next(sig_q, commit.commit_pc, commit.commit_rd_we,
                        commit.commit_rd_value);
    end
  end

  assign signature = sig_q;
`else
  logic unused_commit_pc;

  // The PC only feeds the signature, which is not built here.
  assign unused_commit_pc = ^commit.commit_pc;
  assign signature        = 32'd0;
`endif

endmodule

// File: tb/tb_commit_halt_monitor.sv
// tb_commit_halt_monitor
//   Self-checking bench for commit_halt_monitor (TIMEOUT_CYCLES=50,
//   DRAIN_MAX=8): a table of directed vectors, hand-written multi-cycle
//   sequences (watchdog, drain overrun, commit in drain, async reset,
//   signature trace) and randomized runs against a behavioural model.
module tb_commit_halt_monitor;

  localparam int TMO  = 50;
  localparam int DMAX = 8;
  localparam int CW   = 32;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LI_A0  = 32'h0000_0513;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rob_empty = 1'b0;
  logic          sq_empty = 1'b0;
  logic          halt_fetch, done, pass, fail, timeout;
  logic [31:0]   exit_code, signature;
  logic [CW-1:0] retired_count, cycle_count;

  commit_halt_monitor_if cif ();

  commit_halt_monitor #(
    .TIMEOUT_CYCLES (TMO),
    .DRAIN_MAX      (DMAX),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .commit        (cif.slave),
    .rob_empty     (rob_empty),
    .sq_empty      (sq_empty),
    .halt_fetch    (halt_fetch),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .timeout       (timeout),
    .exit_code     (exit_code),
    .retired_count (retired_count),
    .cycle_count   (cycle_count),
    .signature     (signature)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: phase flags plus the architectural quantities.
  bit            m_drain, m_done, m_tmo, m_err;
  int            m_dcyc;
  logic [31:0]   m_a0, m_exit, m_sig;
  logic [CW-1:0] m_ret, m_cyc;

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] instr;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          re, se;
    bit          e_hf, e_done, e_pass, e_fail, e_tmo;
    logic [31:0] e_exit;
    logic [31:0] e_ret, e_cyc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkVec(bit rst, bit v, logic [31:0] instr, bit we,
                                 int rd, logic [31:0] val, bit re, bit se,
                                 bit hf, bit dn, bit ps, bit fl, bit tm,
                                 logic [31:0] ex, int ret, int cyc);
    vec_t r;
    r.rst = rst; r.v = v; r.instr = instr; r.we = we; r.rd = 5'(rd);
    r.val = val; r.re = re; r.se = se; r.e_hf = hf; r.e_done = dn;
    r.e_pass = ps; r.e_fail = fl; r.e_tmo = tm; r.e_exit = ex;
    r.e_ret = 32'(ret); r.e_cyc = 32'(cyc);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_drain = 1'b0; m_done = 1'b0; m_tmo = 1'b0; m_err = 1'b0;
    m_dcyc = 0; m_a0 = 32'd0; m_exit = 32'd0; m_sig = 32'd0;
    m_ret = '0; m_cyc = '0;
  endtask

  task automatic modelStep(input bit v, input logic [31:0] pc,
                           input logic [31:0] instr, input bit we,
                           input logic [4:0] rd, input logic [31:0] val,
                           input bit re, input bit se);
    bit halt, a0w;
    if (m_done) return;
    if (!m_drain) begin
      halt = v && (instr == ECALL || instr == EBREAK);
      a0w  = v && we && (rd == 5'd10);
      if (v) begin
        m_ret = m_ret + 1'b1;
        m_sig = {m_sig[30:0], m_sig[31]} ^ pc ^ (we ? val : 32'h0);
      end
      if (halt) begin
        m_exit  = a0w ? val : m_a0;
        m_drain = 1'b1;
        m_dcyc  = 0;
      end else if (m_cyc == CW'(TMO - 1)) begin
        m_done = 1'b1;
        m_tmo  = 1'b1;
      end
      if (a0w) m_a0 = val;
      m_cyc = m_cyc + 1'b1;
    end else begin
      m_cyc  = m_cyc + 1'b1;
      m_dcyc = m_dcyc + 1;
      if (v) begin
        m_done = 1'b1;
        m_err  = 1'b1;
      end else if (re && se) begin
        m_done = 1'b1;
      end else if (m_dcyc == DMAX) begin
        m_done = 1'b1;
        m_tmo  = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    bit e_pass;
    e_pass = m_done && (m_exit == 32'd0) && !m_tmo && !m_err;
    checkVal("halt_fetch", 32'(halt_fetch), 32'(m_drain || m_done));
    checkVal("done", 32'(done), 32'(m_done));
    checkVal("pass", 32'(pass), 32'(e_pass));
    checkVal("fail", 32'(fail), 32'(m_done && !e_pass));
    checkVal("timeout", 32'(timeout), 32'(m_done && m_tmo));
    checkVal("exit_code", exit_code, m_exit);
    checkVal("retired_count", retired_count, m_ret);
    checkVal("cycle_count", cycle_count, m_cyc);
`ifdef COMMIT_SIG_EN
    checkVal("signature", signature, m_sig);
`else
    checkVal("signature", signature, 32'd0);
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model on
  // the rising edge and return at the next falling edge for sampling.
  task automatic applyStimulus(input bit v, input logic [31:0] pc,
                               input logic [31:0] instr, input bit we,
                               input logic [4:0] rd, input logic [31:0] val,
                               input bit re, input bit se);
    cif.commit_valid    = v;
    cif.commit_pc       = pc;
    cif.commit_instr    = instr;
    cif.commit_rd_we    = we;
    cif.commit_rd       = rd;
    cif.commit_rd_value = val;
    rob_empty           = re;
    sq_empty            = se;
    @(posedge clk);
    modelStep(v, pc, instr, we, rd, val, re, se);
    @(negedge clk);
  endtask

  task automatic idle(input bit re, input bit se);
    applyStimulus(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0, re, se);
  endtask

  task automatic driveIdle();
    cif.commit_valid = 1'b0; cif.commit_pc = 32'd0; cif.commit_instr = NOP;
    cif.commit_rd_we = 1'b0; cif.commit_rd = 5'd0; cif.commit_rd_value = 32'd0;
    rob_empty = 1'b0; sq_empty = 1'b0;
  endtask

  task automatic doReset();
    driveIdle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput();
  endtask

  initial begin
    logic [31:0] pc, instr, val;
    logic [4:0]  rd;
    bit          v, we, re, se;
    int          halt_at;

    driveIdle();

    // Directed table: li a0,0 + ECALL; a0=5 + EBREAK; same-cycle a0 write;
    // write to x0 must not touch the a0 shadow.
    vecs[0]  = mkVec(1'b1, 1'b1, LI_A0,        1'b1, 10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1, 1);
    vecs[1]  = mkVec(1'b0, 1'b1, ECALL,        1'b0,  0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2, 2);
    vecs[2]  = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2, 3);
    vecs[3]  = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2, 4);
    vecs[4]  = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 2, 5);
    vecs[5]  = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 2, 5);
    vecs[6]  = mkVec(1'b1, 1'b1, 32'h00500513, 1'b1, 10, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1, 1);
    vecs[7]  = mkVec(1'b0, 1'b1, EBREAK,       1'b0,  0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 2, 2);
    vecs[8]  = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 2, 3);
    vecs[9]  = mkVec(1'b1, 1'b1, ECALL,        1'b1, 10, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 1, 1);
    vecs[10] = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 1, 2);
    vecs[11] = mkVec(1'b1, 1'b1, 32'h00900013, 1'b1,  0, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1, 1);
    vecs[12] = mkVec(1'b0, 1'b1, ECALL,        1'b0,  0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2, 2);
    vecs[13] = mkVec(1'b0, 1'b0, NOP,          1'b0,  0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 2, 3);

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].v, 32'h100 + 32'(i) * 32'd4, vecs[i].instr, vecs[i].we,
                    vecs[i].rd, vecs[i].val, vecs[i].re, vecs[i].se);
      checkVal($sformatf("vec%0d.halt_fetch", i), 32'(halt_fetch), 32'(vecs[i].e_hf));
      checkVal($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].e_done));
      checkVal($sformatf("vec%0d.pass", i), 32'(pass), 32'(vecs[i].e_pass));
      checkVal($sformatf("vec%0d.fail", i), 32'(fail), 32'(vecs[i].e_fail));
      checkVal($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(vecs[i].e_tmo));
      checkVal($sformatf("vec%0d.exit_code", i), exit_code, vecs[i].e_exit);
      checkVal($sformatf("vec%0d.retired", i), retired_count, vecs[i].e_ret);
      checkVal($sformatf("vec%0d.cycles", i), cycle_count, vecs[i].e_cyc);
      checkOutput();
    end

    // Watchdog: no halt, done appears after exactly TMO cycles.
    doReset();
    for (int c = 0; c < TMO - 1; c++) begin
      idle(1'b1, 1'b1);
      checkOutput();
    end
    checkVal("wdog.done_early", 32'(done), 32'd0);
    idle(1'b1, 1'b1);
    checkOutput();
    checkVal("wdog.done", 32'(done), 32'd1);
    checkVal("wdog.fail", 32'(fail), 32'd1);
    checkVal("wdog.timeout", 32'(timeout), 32'd1);
    checkVal("wdog.cycle_count", cycle_count, 32'd50);

    // Drain overrun: store queue never empties.
    doReset();
    applyStimulus(1'b1, 32'h200, LI_A0, 1'b1, 5'd10, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h204, ECALL, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    for (int c = 0; c < DMAX - 1; c++) begin
      idle(1'b1, 1'b0);
      checkOutput();
    end
    checkVal("drainmax.done_early", 32'(done), 32'd0);
    idle(1'b1, 1'b0);
    checkOutput();
    checkVal("drainmax.fail", 32'(fail), 32'd1);
    checkVal("drainmax.timeout", 32'(timeout), 32'd1);

    // A commit while draining is a protocol error, not a timeout.
    doReset();
    applyStimulus(1'b1, 32'h300, ECALL, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, NOP, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    checkVal("drainerr.fail", 32'(fail), 32'd1);
    checkVal("drainerr.timeout", 32'(timeout), 32'd0);

    // Asynchronous reset in the middle of DRAIN clears outputs at once.
    doReset();
    applyStimulus(1'b1, 32'h400, 32'h00300513, 1'b1, 5'd10, 32'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, ECALL, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkVal("arst.pre_halt_fetch", 32'(halt_fetch), 32'd1);
    driveIdle();
    #2 reset = 1'b1;
    #1;
    checkVal("arst.halt_fetch", 32'(halt_fetch), 32'd0);
    checkVal("arst.exit_code", exit_code, 32'd0);
    checkVal("arst.retired", retired_count, 32'd0);
    checkVal("arst.cycles", cycle_count, 32'd0);
    checkVal("arst.done", 32'({done, pass, fail, timeout}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput();
    applyStimulus(1'b1, 32'h500, LI_A0, 1'b1, 5'd10, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h504, ECALL, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    checkOutput();
    checkVal("arst.rerun_pass", 32'(pass), 32'd1);

    // Fixed four-commit signature trace, golden value worked by hand.
    doReset();
    applyStimulus(1'b1, 32'h100, NOP, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, 32'h00500293, 1'b1, 5'd5, 32'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h108, 32'h0a000313, 1'b1, 5'd6, 32'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10C, ECALL, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
`ifdef COMMIT_SIG_EN
    checkVal("sig.golden", signature, 32'h0000_0E58);
`else
    checkVal("sig.golden", signature, 32'd0);
`endif
    idle(1'b1, 1'b1);
    checkOutput();
    checkVal("sig.pass", 32'(pass), 32'd1);

    // Randomized runs against the model.
    for (int s = 0; s < 25; s++) begin
      doReset();
      halt_at = $urandom_range(1, 60);
      for (int c = 0; c < 70; c++) begin
        pc  = $urandom;
        we  = 1'($urandom);
        rd  = ($urandom_range(0, 2) == 0) ? 5'd10 : 5'($urandom);
        val = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
        instr = $urandom;
        if (instr == ECALL || instr == EBREAK) instr = NOP;
        re = ($urandom_range(0, 2) == 0);
        se = ($urandom_range(0, 2) == 0);
        if (!m_drain && !m_done) begin
          v = 1'($urandom);
          if (c == halt_at) begin
            v = 1'b1;
            instr = ($urandom_range(0, 1) == 0) ? ECALL : EBREAK;
          end
        end else begin
          v = ($urandom_range(0, 15) == 0);
        end
        applyStimulus(v, pc, instr, we, rd, val, re, se);
        checkOutput();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
